// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter that shares the single register-file
// write port among N_REQ writeback requesters, with a 32-entry pending-write
// scoreboard for RAW stalls and a sticky halt on finish_flag.
// Optional statistics counters are built when RF_ARB_STATS_EN is defined.
module regfile_write_arbiter #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 32,
  parameter int STAT_W = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    finish_flag,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [5*N_REQ-1:0]      req_rd,
  input  logic [DATA_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    RegWrite,
  output logic [4:0]              RD,
  output logic [DATA_W-1:0]       WriteData,
  input  logic                    sb_set_valid,
  input  logic [4:0]              sb_set_rd,
  output logic [31:0]             sb_pending,
  output logic                    halted
`ifdef RF_ARB_STATS_EN
  ,
  output logic [STAT_W*N_REQ-1:0] stat_grants,
  output logic [STAT_W-1:0]       stat_conflicts
`endif
);

  localparam int PTR_W = (N_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, HALT = 2'd2} state_t;

  state_t              state, state_d;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W:0]      cand;
  logic                grant_any;
  logic [PTR_W-1:0]    grant_idx;
  logic [N_REQ-1:0]    grant_vec;
  logic [4:0]          sel_rd;
  logic [DATA_W-1:0]   sel_data;
  logic [31:0]         sb_d;

  // Round-robin search starting after the last granted requester; the grant is
  // suppressed in reset, in HALT and in the cycle finish_flag is seen.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(k + 1);
      if (cand >= (PTR_W+1)'(N_REQ)) cand = cand - (PTR_W+1)'(N_REQ);
      for (int j = 0; j < N_REQ; j++) begin
        if (!grant_any && cand == (PTR_W+1)'(j) && req_valid[j]) begin
          grant_any = 1'b1;
          grant_idx = PTR_W'(j);
        end
      end
    end
    if (state == HALT || finish_flag || !reset_n) grant_any = 1'b0;
  end

  // One-hot grant and the selected requester's write payload.
  always_comb begin
    grant_vec = '0;
    sel_rd    = '0;
    sel_data  = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (grant_any && grant_idx == PTR_W'(j)) begin
        grant_vec[j] = 1'b1;
        sel_rd       = req_rd[5*j +: 5];
        sel_data     = req_data[DATA_W*j +: DATA_W];
      end
    end
  end

  assign req_ready = grant_vec;
  assign halted    = (state == HALT);

  // Next state: HALT is absorbing; otherwise WRITE tracks whether a write was just granted.
  always_comb begin
    state_d = state;
    if (state != HALT) begin
      if (finish_flag)    state_d = HALT;
      else if (grant_any) state_d = WRITE;
      else                state_d = IDLE;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  // Scoreboard next value: a grant clears its rd, a decode reservation sets (and wins).
  always_comb begin
    sb_d = sb_pending;
    if (grant_any) sb_d[sel_rd] = 1'b0;
    if (state != HALT && sb_set_valid && sb_set_rd != 5'd0) sb_d[sb_set_rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  // Output register stage, round-robin pointer and scoreboard; writes to x0 are
  // accepted but never raise RegWrite.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr     <= PTR_W'(N_REQ - 1);
      RegWrite   <= 1'b0;
      RD         <= '0;
      WriteData  <= '0;
      sb_pending <= '0;
    end else begin
      RegWrite   <= grant_any && (sel_rd != 5'd0);
      sb_pending <= sb_d;
      if (grant_any) begin
        rr_ptr    <= grant_idx;
        RD        <= sel_rd;
        WriteData <= sel_data;
      end
    end
  end

`ifdef RF_ARB_STATS_EN
  logic [STAT_W-1:0] grants_q [N_REQ];
  logic [2:0]        nvalid;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  // Count of simultaneously valid requesters for conflict statistics.
  always_comb begin
    nvalid = '0;
    for (int j = 0; j < N_REQ; j++) nvalid = nvalid + {2'b00, req_valid[j]};
  end

  // Saturating statistics counters, frozen once halted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < N_REQ; j++) grants_q[j] <= '0;
      stat_conflicts <= '0;
    end else if (state != HALT) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (grant_vec[j]) grants_q[j] <= sat_inc(grants_q[j]);
      end
      if (nvalid >= 3'd2) stat_conflicts <= sat_inc(stat_conflicts);
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_stat
    assign stat_grants[STAT_W*g +: STAT_W] = grants_q[g];
  end
`else
  logic unused_stat_cfg;
  assign unused_stat_cfg = (STAT_W > 0);
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed, table-driven bench for regfile_write_arbiter (N_REQ=3, DATA_W=32).
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        finish_flag;
  logic [2:0]  req_valid;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        RegWrite;
  logic [4:0]  RD;
  logic [31:0] WriteData;
  logic        sb_set_valid;
  logic [4:0]  sb_set_rd;
  logic [31:0] sb_pending;
  logic        halted;
`ifdef RF_ARB_STATS_EN
  logic [47:0] stat_grants;
  logic [15:0] stat_conflicts;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  regfile_write_arbiter #(.N_REQ(3), .DATA_W(32), .STAT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .finish_flag(finish_flag),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
    .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData),
    .sb_set_valid(sb_set_valid), .sb_set_rd(sb_set_rd), .sb_pending(sb_pending),
    .halted(halted)
`ifdef RF_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_conflicts(stat_conflicts)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0]  valid;
    logic [14:0] rd;
    logic [95:0] data;
    logic        set_v;
    logic [4:0]  set_rd;
    logic [2:0]  exp_ready;
    logic        exp_rw;
    logic [4:0]  exp_rd;
    logic [31:0] exp_wd;
    logic [31:0] exp_sb;
  } vec_t;

  vec_t vec [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    finish_flag  = 1'b0;
    req_valid    = '0;
    req_rd       = '0;
    req_data     = '0;
    sb_set_valid = 1'b0;
    sb_set_rd    = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    // Table: runs continuously from reset; rr_ptr starts at 2.
    vec[0]  = '{3'b000, 15'd0, 96'd0, 1'b1, 5'd5,
                3'b000, 1'b0, 5'd0, 32'h0, 32'h0000_0020};
    vec[1]  = '{3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'h1234}, 1'b0, 5'd0,
                3'b001, 1'b1, 5'd5, 32'h1234, 32'h0};
    vec[2]  = '{3'b111, {5'd3, 5'd2, 5'd1}, {32'hA2, 32'hA1, 32'hA0}, 1'b0, 5'd0,
                3'b010, 1'b1, 5'd2, 32'hA1, 32'h0};
    vec[3]  = '{3'b111, {5'd3, 5'd2, 5'd1}, {32'hA2, 32'hA1, 32'hA0}, 1'b0, 5'd0,
                3'b100, 1'b1, 5'd3, 32'hA2, 32'h0};
    vec[4]  = '{3'b111, {5'd3, 5'd2, 5'd1}, {32'hA2, 32'hA1, 32'hA0}, 1'b0, 5'd0,
                3'b001, 1'b1, 5'd1, 32'hA0, 32'h0};
    vec[5]  = '{3'b010, 15'd0, {32'h0, 32'hFFFF, 32'h0}, 1'b0, 5'd0,
                3'b010, 1'b0, 5'd0, 32'hFFFF, 32'h0};
    vec[6]  = '{3'b000, 15'd0, 96'd0, 1'b0, 5'd0,
                3'b000, 1'b0, 5'd0, 32'hFFFF, 32'h0};
    vec[7]  = '{3'b100, {5'd7, 5'd0, 5'd0}, {32'h77, 32'h0, 32'h0}, 1'b1, 5'd7,
                3'b100, 1'b1, 5'd7, 32'h77, 32'h0000_0080};
    vec[8]  = '{3'b001, {5'd0, 5'd0, 5'd7}, {32'h0, 32'h0, 32'h78}, 1'b1, 5'd9,
                3'b001, 1'b1, 5'd7, 32'h78, 32'h0000_0200};
    vec[9]  = '{3'b101, {5'd6, 5'd0, 5'd4}, {32'h60, 32'h0, 32'h40}, 1'b0, 5'd0,
                3'b100, 1'b1, 5'd6, 32'h60, 32'h0000_0200};
    vec[10] = '{3'b101, {5'd6, 5'd0, 5'd4}, {32'h60, 32'h0, 32'h40}, 1'b0, 5'd0,
                3'b001, 1'b1, 5'd4, 32'h40, 32'h0000_0200};

    // Reset state, with requesters already valid.
    idle_inputs();
    reset_n   = 1'b0;
    req_valid = 3'b111;
    #3;
    chk("reset_ready", 64'(req_ready), 64'd0);
    chk("reset_regwrite", 64'(RegWrite), 64'd0);
    chk("reset_rd", 64'(RD), 64'd0);
    chk("reset_wdata", 64'(WriteData), 64'd0);
    chk("reset_sb", 64'(sb_pending), 64'd0);
    chk("reset_halted", 64'(halted), 64'd0);
    do_reset();

    // Table-driven vectors.
    for (int i = 0; i < 11; i++) begin
      req_valid    = vec[i].valid;
      req_rd       = vec[i].rd;
      req_data     = vec[i].data;
      sb_set_valid = vec[i].set_v;
      sb_set_rd    = vec[i].set_rd;
      #1;
      chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'(vec[i].exp_ready));
      tick();
      chk($sformatf("v%0d_regwrite", i), 64'(RegWrite), 64'(vec[i].exp_rw));
      chk($sformatf("v%0d_rd", i), 64'(RD), 64'(vec[i].exp_rd));
      chk($sformatf("v%0d_wdata", i), 64'(WriteData), 64'(vec[i].exp_wd));
      chk($sformatf("v%0d_sb", i), 64'(sb_pending), 64'(vec[i].exp_sb));
    end

    // All three valid continuously from reset: grants rotate 0,1,2,0,1,2.
    do_reset();
    req_valid = 3'b111;
    req_rd    = {5'd3, 5'd2, 5'd1};
    req_data  = {32'hC2, 32'hC1, 32'hC0};
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("rr%0d_ready", i), 64'(req_ready), 64'(3'b001 << (i % 3)));
      tick();
      chk($sformatf("rr%0d_regwrite", i), 64'(RegWrite), 64'd1);
      chk($sformatf("rr%0d_rd", i), 64'(RD), 64'((i % 3) + 1));
    end

    // finish_flag right after a granted write.
    do_reset();
    req_valid    = 3'b001;
    req_rd       = {5'd0, 5'd0, 5'd3};
    req_data     = {32'h0, 32'h0, 32'h333};
    sb_set_valid = 1'b1;
    sb_set_rd    = 5'd10;
    tick();
    sb_set_valid = 1'b0;
    finish_flag  = 1'b1;
    req_valid    = 3'b100;
    req_rd       = {5'd4, 5'd0, 5'd0};
    #1;
    chk("fin_ready", 64'(req_ready), 64'd0);
    chk("fin_regwrite_n1", 64'(RegWrite), 64'd1);
    chk("fin_rd_n1", 64'(RD), 64'd3);
    tick();
    finish_flag  = 1'b0;
    sb_set_valid = 1'b1;
    sb_set_rd    = 5'd12;
    chk("fin_halted", 64'(halted), 64'd1);
    chk("fin_regwrite_n2", 64'(RegWrite), 64'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("halt%0d_ready", i), 64'(req_ready), 64'd0);
      tick();
      chk($sformatf("halt%0d_regwrite", i), 64'(RegWrite), 64'd0);
      chk($sformatf("halt%0d_sb", i), 64'(sb_pending), 64'h0000_0400);
      chk($sformatf("halt%0d_halted", i), 64'(halted), 64'd1);
    end

    // Asynchronous reset while a write is on the output port.
    do_reset();
    req_valid    = 3'b001;
    req_rd       = {5'd0, 5'd0, 5'd5};
    req_data     = {32'h0, 32'h0, 32'h55};
    sb_set_valid = 1'b1;
    sb_set_rd    = 5'd20;
    tick();
    idle_inputs();
    chk("ar_regwrite_before", 64'(RegWrite), 64'd1);
    chk("ar_sb_before", 64'(sb_pending), 64'h0010_0000);
`ifdef RF_ARB_STATS_EN
    chk("ar_stat_g0_before", 64'(stat_grants[15:0]), 64'd1);
`endif
    reset_n = 1'b0;
    #1;
    chk("ar_regwrite", 64'(RegWrite), 64'd0);
    chk("ar_sb", 64'(sb_pending), 64'd0);
    chk("ar_rd", 64'(RD), 64'd0);
    chk("ar_wdata", 64'(WriteData), 64'd0);
`ifdef RF_ARB_STATS_EN
    chk("ar_stat_grants", 64'(stat_grants), 64'd0);
    chk("ar_stat_conflicts", 64'(stat_conflicts), 64'd0);
`endif
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
